// File: rtl/pixel_coord_gen.sv
// pixel_coord_gen
// Raster-order complex-coordinate generator feeding the Mandelbrot engine.
// View parameters are latched once per frame; per-pixel coordinates are
// produced by one adder per axis, so no multiply sits in the pixel path.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no frame in flight, waiting for frame_start
// SETUP  | one cycle: derive step and top-left corner from latched view
// STREAM | one point presented per cycle, advanced on valid && ready
module pixel_coord_gen #(
  parameter int COORD_WIDTH = 16,
  parameter int ZOOM_WIDTH  = 8,
  parameter int ITER_WIDTH  = 6,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int PX_W        = 10,
  parameter int BASE_STEP   = 19
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic [COORD_WIDTH-1:0] centre_x,
  input  logic [COORD_WIDTH-1:0] centre_y,
  input  logic [ZOOM_WIDTH-1:0]  zoom_level,
  input  logic [ITER_WIDTH-1:0]  max_iter_limit,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COORD_WIDTH-1:0] out_cr,
  output logic [COORD_WIDTH-1:0] out_ci,
  output logic [PX_W-1:0]        out_px_x,
  output logic [PX_W-1:0]        out_px_y,
  output logic [ITER_WIDTH-1:0]  out_max_iter,
  output logic                   out_eol,
  output logic                   out_eof,
  output logic                   busy,
  output logic                   frame_overrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam logic [COORD_WIDTH-1:0] BASE   = COORD_WIDTH'(BASE_STEP);
  localparam logic [COORD_WIDTH-1:0] HALF_H = COORD_WIDTH'(H_RES / 2);
  localparam logic [COORD_WIDTH-1:0] HALF_V = COORD_WIDTH'(V_RES / 2);
  localparam logic [PX_W-1:0]        LAST_X = PX_W'(H_RES - 1);
  localparam logic [PX_W-1:0]        LAST_Y = PX_W'(V_RES - 1);
  localparam logic [ZOOM_WIDTH-1:0]  ZOOM_MAX = ZOOM_WIDTH'(15);

  state_t state, state_nxt;

  // View parameters frozen for the frame in flight
  logic [COORD_WIDTH-1:0] lat_cx;
  logic [COORD_WIDTH-1:0] lat_cy;
  logic [ZOOM_WIDTH-1:0]  lat_zoom;
  logic [ITER_WIDTH-1:0]  lat_iter;

  // Per-frame derived values and the running pixel position
  logic [COORD_WIDTH-1:0] step_q;
  logic [COORD_WIDTH-1:0] x0_q;
  logic [COORD_WIDTH-1:0] cr_q;
  logic [COORD_WIDTH-1:0] ci_q;
  logic [PX_W-1:0]        px_x_q;
  logic [PX_W-1:0]        px_y_q;
  logic                   overrun_q;

  logic [3:0]             zoom_clamped;
  logic [COORD_WIDTH-1:0] step_shift;
  logic [COORD_WIDTH-1:0] step_calc;
  logic [COORD_WIDTH-1:0] x_off;
  logic [COORD_WIDTH-1:0] y_off;
  logic [COORD_WIDTH-1:0] x0_calc;
  logic [COORD_WIDTH-1:0] y0_calc;
  logic                   transfer;
  logic                   at_eol;
  logic                   at_eof;

  // Step and top-left corner from the latched view; only consumed in SETUP
  always_comb begin
    zoom_clamped = 4'd15;
    if (lat_zoom <= ZOOM_MAX) begin
      zoom_clamped = lat_zoom[3:0];
    end
    step_shift = BASE >> zoom_clamped;
    // A step of zero would collapse the frame onto one point; deep zooms floor at 1 LSB
    step_calc  = (step_shift == '0) ? COORD_WIDTH'(1) : step_shift;
    x_off      = step_calc * HALF_H;
    y_off      = step_calc * HALF_V;
    x0_calc    = lat_cx - x_off;
    y0_calc    = lat_cy - y_off;
  end

  assign out_valid     = (state == STREAM);
  assign busy          = (state != IDLE);
  assign transfer      = out_valid && out_ready;
  assign at_eol        = (px_x_q == LAST_X);
  assign at_eof        = at_eol && (px_y_q == LAST_Y);
  assign out_cr        = cr_q;
  assign out_ci        = ci_q;
  assign out_px_x      = px_x_q;
  assign out_px_y      = px_y_q;
  assign out_max_iter  = lat_iter;
  assign out_eol       = at_eol;
  assign out_eof       = at_eof;
  assign frame_overrun = overrun_q;

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (frame_start) begin
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        state_nxt = STREAM;
      end
      STREAM: begin
        if (transfer && at_eof) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Overrun flag: a frame_start seen while a frame is still in flight,
  // including the cycle of the final transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= frame_start && (state != IDLE);
    end
  end

  // Parameter latch, frame setup and incremental raster stepping
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cx   <= '0;
      lat_cy   <= '0;
      lat_zoom <= '0;
      lat_iter <= '0;
      step_q   <= '0;
      x0_q     <= '0;
      cr_q     <= '0;
      ci_q     <= '0;
      px_x_q   <= '0;
      px_y_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            lat_cx   <= centre_x;
            lat_cy   <= centre_y;
            lat_zoom <= zoom_level;
            lat_iter <= max_iter_limit;
          end
        end
        SETUP: begin
          step_q <= step_calc;
          x0_q   <= x0_calc;
          cr_q   <= x0_calc;
          ci_q   <= y0_calc;
          px_x_q <= '0;
          px_y_q <= '0;
        end
        STREAM: begin
          if (transfer) begin
            if (at_eol) begin
              cr_q   <= x0_q;
              ci_q   <= ci_q + step_q;
              px_x_q <= '0;
              // Final point parks the row counter at 0 so it never exceeds V_RES-1
              if (at_eof) begin
                px_y_q <= '0;
              end else begin
                px_y_q <= px_y_q + PX_W'(1);
              end
            end else begin
              cr_q   <= cr_q + step_q;
              px_x_q <= px_x_q + PX_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_coord_gen.sv
// Testbench for pixel_coord_gen: a full-size instance (640x480, frames
// aborted by reset after a few lines) and a 4x3 instance for whole frames.
module tb_pixel_coord_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        rst        [2];
  logic        fs         [2];
  logic [15:0] cxs        [2];
  logic [15:0] cys        [2];
  logic [7:0]  zms        [2];
  logic [5:0]  its        [2];
  logic        rdy        [2];
  logic        o_valid    [2];
  logic [15:0] o_cr       [2];
  logic [15:0] o_ci       [2];
  logic [9:0]  o_px       [2];
  logic [9:0]  o_py       [2];
  logic [5:0]  o_iter     [2];
  logic        o_eol      [2];
  logic        o_eof      [2];
  logic        o_busy     [2];
  logic        o_ovr      [2];

  pixel_coord_gen #(.H_RES(640), .V_RES(480)) u_full (
    .clk(clk), .rst(rst[0]), .frame_start(fs[0]),
    .centre_x(cxs[0]), .centre_y(cys[0]), .zoom_level(zms[0]), .max_iter_limit(its[0]),
    .out_valid(o_valid[0]), .out_ready(rdy[0]), .out_cr(o_cr[0]), .out_ci(o_ci[0]),
    .out_px_x(o_px[0]), .out_px_y(o_py[0]), .out_max_iter(o_iter[0]),
    .out_eol(o_eol[0]), .out_eof(o_eof[0]), .busy(o_busy[0]), .frame_overrun(o_ovr[0])
  );

  pixel_coord_gen #(.H_RES(4), .V_RES(3)) u_small (
    .clk(clk), .rst(rst[1]), .frame_start(fs[1]),
    .centre_x(cxs[1]), .centre_y(cys[1]), .zoom_level(zms[1]), .max_iter_limit(its[1]),
    .out_valid(o_valid[1]), .out_ready(rdy[1]), .out_cr(o_cr[1]), .out_ci(o_ci[1]),
    .out_px_x(o_px[1]), .out_px_y(o_py[1]), .out_max_iter(o_iter[1]),
    .out_eol(o_eol[1]), .out_eof(o_eof[1]), .busy(o_busy[1]), .frame_overrun(o_ovr[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int h_of(input int sel);
    return (sel == 0) ? 640 : 4;
  endfunction

  function automatic int v_of(input int sel);
    return (sel == 0) ? 480 : 3;
  endfunction

  task automatic check_all_zero(input int sel, input string tag);
    check({tag, "_valid"}, 32'(o_valid[sel]), 0);
    check({tag, "_busy"},  32'(o_busy[sel]),  0);
    check({tag, "_ovr"},   32'(o_ovr[sel]),   0);
    check({tag, "_cr"},    32'(o_cr[sel]),    0);
    check({tag, "_ci"},    32'(o_ci[sel]),    0);
    check({tag, "_px"},    32'(o_px[sel]),    0);
    check({tag, "_py"},    32'(o_py[sel]),    0);
    check({tag, "_iter"},  32'(o_iter[sel]),  0);
    check({tag, "_eol"},   32'(o_eol[sel]),   0);
    check({tag, "_eof"},   32'(o_eof[sel]),   0);
  endtask

  // One frame on instance sel. rnd: random out_ready. inject_at: point index
  // at whose transfer a second frame_start is driven (-1 none). abort_at:
  // point index at which rst is raised instead of continuing (-1 none).
  task automatic run_frame(input int sel, input logic [15:0] cx, input logic [15:0] cy,
                           input logic [7:0] zm, input logic [5:0] it,
                           input bit rnd, input int inject_at, input int abort_at);
    int h = h_of(sel);
    int v = v_of(sel);
    int total = h * v;
    int idx = 0;
    int budget = total * 8 + 20;
    int z;
    int stp;
    int ex;
    int ey;
    logic [15:0] e_cr;
    logic [15:0] e_ci;
    bit prev_stall = 0;
    bit ov_exp = 0;
    bit literal_view;
    logic [15:0] s_cr;
    logic [15:0] s_ci;
    logic [9:0]  s_px;
    logic [9:0]  s_py;

    z = (zm > 8'd15) ? 15 : int'(zm);
    stp = 19 >> z;
    if (stp == 0) stp = 1;
    literal_view = (sel == 0) && (cx == 16'hF000) && (cy == 16'h0000);

    @(negedge clk);
    fs[sel] = 1'b1; cxs[sel] = cx; cys[sel] = cy; zms[sel] = zm; its[sel] = it;
    rdy[sel] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    fs[sel] = 1'b0;
    // Inputs wander from here on; the latched frame must not notice
    cxs[sel] = 16'($urandom); cys[sel] = 16'($urandom);
    zms[sel] = 8'($urandom); its[sel] = 6'($urandom);
    check("setup_valid", 32'(o_valid[sel]), 0);
    check("setup_busy", 32'(o_busy[sel]), 1);

    while (idx < total && budget > 0) begin
      @(negedge clk);
      budget--;
      fs[sel] = 1'b0;
      check("overrun", 32'(o_ovr[sel]), 32'(ov_exp));
      ov_exp = 0;
      if (prev_stall) begin
        check("hold_cr", 32'(o_cr[sel]), 32'(s_cr));
        check("hold_ci", 32'(o_ci[sel]), 32'(s_ci));
        check("hold_px", 32'(o_px[sel]), 32'(s_px));
        check("hold_py", 32'(o_py[sel]), 32'(s_py));
      end
      ex = idx % h;
      ey = idx / h;
      e_cr = 16'(int'(cx) - stp * (h / 2) + ex * stp);
      e_ci = 16'(int'(cy) - stp * (v / 2) + ey * stp);
      check("valid", 32'(o_valid[sel]), 1);
      check("busy",  32'(o_busy[sel]), 1);
      check("px_x",  32'(o_px[sel]), 32'(ex));
      check("px_y",  32'(o_py[sel]), 32'(ey));
      check("cr",    32'(o_cr[sel]), 32'(e_cr));
      check("ci",    32'(o_ci[sel]), 32'(e_ci));
      check("iter",  32'(o_iter[sel]), 32'(it));
      check("eol",   32'(o_eol[sel]), 32'(ex == h - 1));
      check("eof",   32'(o_eof[sel]), 32'((ex == h - 1) && (ey == v - 1)));
      if (literal_view && zm == 8'd0) begin
        if (idx == 0)   begin check("lit_cr00", 32'(o_cr[sel]), 32'hD840);
                              check("lit_ci00", 32'(o_ci[sel]), 32'hEE30); end
        if (idx == 1)         check("lit_cr10", 32'(o_cr[sel]), 32'hD853);
        if (idx == 639) begin check("lit_cr639", 32'(o_cr[sel]), 32'h07AD);
                              check("lit_eol639", 32'(o_eol[sel]), 1); end
        if (idx == 640) begin check("lit_cr01", 32'(o_cr[sel]), 32'hD840);
                              check("lit_ci01", 32'(o_ci[sel]), 32'hEE43); end
      end
      if (literal_view && zm >= 8'd4) begin
        if (idx == 0) check("lit_zoom_x0", 32'(o_cr[sel]), 32'hEEC0);
        if (idx == 1) check("lit_zoom_x1", 32'(o_cr[sel]), 32'hEEC1);
      end
      if (idx == abort_at) begin
        rst[sel] = 1'b1;
        @(negedge clk);
        check_all_zero(sel, "abort");
        rst[sel] = 1'b0;
        @(negedge clk);
        check("abort_idle_valid", 32'(o_valid[sel]), 0);
        return;
      end
      rdy[sel] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx == inject_at) begin
        rdy[sel] = 1'b1;
        fs[sel] = 1'b1;
        cxs[sel] = cx + 16'h1234;
        ov_exp = 1;
      end
      prev_stall = !rdy[sel];
      s_cr = o_cr[sel]; s_ci = o_ci[sel]; s_px = o_px[sel]; s_py = o_py[sel];
      if (rdy[sel]) idx++;
    end
    check("xfers", 32'(idx), 32'(total));

    @(negedge clk);
    fs[sel] = 1'b0;
    check("end_overrun", 32'(o_ovr[sel]), 32'(ov_exp));
    check("end_valid", 32'(o_valid[sel]), 0);
    check("end_busy", 32'(o_busy[sel]), 0);
    @(negedge clk);
    check("idle_overrun", 32'(o_ovr[sel]), 0);
    check("idle_busy", 32'(o_busy[sel]), 0);
    check("idle_valid", 32'(o_valid[sel]), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; fs[s] = 1'b0; cxs[s] = '0; cys[s] = '0;
      zms[s] = '0; its[s] = '0; rdy[s] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) check_all_zero(s, "reset");
    for (int s = 0; s < 2; s++) rst[s] = 1'b0;
    @(negedge clk);

    // Full-size view: first lines, then zoom clamp, then a random view
    run_frame(0, 16'hF000, 16'h0000, 8'd0,   6'd20, 0, -1, 645);
    run_frame(0, 16'hF000, 16'h0000, 8'd4,   6'd7,  0, -1, 3);
    run_frame(0, 16'hF000, 16'h0000, 8'd8,   6'd7,  0, -1, 3);
    run_frame(0, 16'hF000, 16'h0000, 8'd255, 6'd7,  0, -1, 3);
    run_frame(0, 16'($urandom), 16'($urandom), 8'($urandom_range(0, 20)), 6'($urandom), 1, -1, 50);

    // Small frames: backpressure, overrun mid-frame and on the final point
    for (int k = 0; k < 3; k++)
      run_frame(1, 16'($urandom), 16'($urandom), 8'($urandom), 6'($urandom), 1, -1, -1);
    run_frame(1, 16'($urandom), 16'($urandom), 8'($urandom_range(0, 5)), 6'($urandom), 1, 5, -1);
    run_frame(1, 16'($urandom), 16'($urandom), 8'($urandom_range(0, 5)), 6'($urandom), 1, 11, -1);

    // Reset at pixel (2,1), then a clean restart
    run_frame(1, 16'h0100, 16'hFF00, 8'd1, 6'd33, 1, -1, 6);
    run_frame(1, 16'h0100, 16'hFF00, 8'd1, 6'd33, 0, -1, -1);

    // Real axis wraps across the signed boundary
    run_frame(1, 16'h7FF0, 16'h0000, 8'd0, 6'd9, 0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
